// File: rtl/sipo_rx_ctrl_pkg.sv
// Shared types and helpers for the serial-in/parallel-out frame receiver.
package sipo_rx_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY,
        STOP
    } state_t;

    // High when data bits plus parity bit disagree with the chosen sense.
    function automatic logic parity_of(
        input logic [31:0] word,
        input logic        pbit,
        input logic        odd
    );
        return (^word) ^ pbit ^ odd;
    endfunction

endpackage

// File: rtl/sipo_shreg.sv
// WIDTH-bit left-shifting register; new bits enter at bit 0.
module sipo_shreg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q <= '0;
        else if (en)
            q <= {q[WIDTH-2:0], d};
    end

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Frame controller: start bit, WIDTH data bits MSB-first, optional parity,
// stop bit; good words are handed out on a double-buffered valid/ready port.
import sipo_rx_ctrl_pkg::*;

module sipo_rx_ctrl #(
    parameter int WIDTH      = 4,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_in,
    input  logic             s_valid,
    input  logic             clr,
    output logic [WIDTH-1:0] p_data,
    output logic             p_valid,
    input  logic             p_ready,
    output logic             busy,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             par_bad;
    logic [WIDTH-1:0] shreg_q;
    logic             shift_en;
    logic             stop_hit;
    logic             good;

    assign shift_en = !clr && s_valid && (state == SHIFT);
    assign stop_hit = s_valid && (state == STOP);
    assign good     = stop_hit && s_in && !par_bad;
    assign busy     = (state != IDLE);

    sipo_shreg #(
        .WIDTH(WIDTH)
    ) u_shreg (
        .clk  (clk),
        .reset(reset),
        .en   (shift_en),
        .d    (s_in),
        .q    (shreg_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            par_bad    <= 1'b0;
            p_data     <= '0;
            p_valid    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            if (clr) begin
                state   <= IDLE;
                cnt     <= '0;
                par_bad <= 1'b0;
                p_valid <= 1'b0;
            end else begin
                // A good word may replace the held one only if it is taken now.
                if (good) begin
                    if (!p_valid || p_ready) begin
                        p_data  <= shreg_q;
                        p_valid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end else if (p_valid && p_ready) begin
                    p_valid <= 1'b0;
                end

                if (s_valid) begin
                    unique case (state)
                        IDLE: begin
                            if (!s_in) begin
                                state   <= SHIFT;
                                cnt     <= '0;
                                par_bad <= 1'b0;
                            end
                        end
                        SHIFT: begin
                            cnt <= cnt + 1'b1;
                            if (cnt == CW'(WIDTH - 1))
                                state <= PARITY_EN ? PARITY : STOP;
                        end
                        PARITY: begin
                            par_bad <= parity_of(32'(shreg_q), s_in,
                                                 PARITY_ODD);
                            state   <= STOP;
                        end
                        STOP: begin
                            state      <= IDLE;
                            frame_err  <= !s_in;
                            parity_err <= s_in && par_bad;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Directed plus randomized frames checked against a frame-level model.
module tb_sipo_rx_ctrl;

    localparam int W    = 4;
    localparam bit P_EN = 1'b1;
    localparam bit P_OD = 1'b0;

    logic         clk = 1'b0;
    logic         reset;
    logic         s_in;
    logic         s_valid;
    logic         clr;
    logic [W-1:0] p_data;
    logic         p_valid;
    logic         p_ready;
    logic         busy;
    logic         parity_err;
    logic         frame_err;
    logic         overrun;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] m_data;
    logic         m_valid;

    sipo_rx_ctrl #(
        .WIDTH     (W),
        .PARITY_EN (P_EN),
        .PARITY_ODD(P_OD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_in      (s_in),
        .s_valid   (s_valid),
        .clr       (clr),
        .p_data    (p_data),
        .p_valid   (p_valid),
        .p_ready   (p_ready),
        .busy      (busy),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bit_strobe(input logic b, input int gap);
        s_in    = b;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        s_in    = 1'($urandom);
        repeat (gap) tick();
    endtask

    function automatic int rgap(input int maxgap);
        return (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap));
    endfunction

    task automatic start_bits(input logic [W-1:0] d, input int nbits,
                              input int maxgap);
        if (maxgap > 0)
            repeat (rgap(2)) bit_strobe(1'b1, rgap(maxgap));
        bit_strobe(1'b0, rgap(maxgap));
        check("busy_after_start", 32'(busy), 32'd1);
        for (int i = W - 1; i >= W - nbits; i--)
            bit_strobe(d[i], rgap(maxgap));
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic pb,
                              input logic sb, input int maxgap,
                              input logic rdy);
        logic par_ok;
        logic good;
        logic e_ovr;
        start_bits(d, W, maxgap);
        if (P_EN)
            bit_strobe(pb, rgap(maxgap));
        s_in    = sb;
        s_valid = 1'b1;
        p_ready = rdy;
        tick();
        s_valid = 1'b0;
        p_ready = 1'b0;

        par_ok = !P_EN || (($countones(d) + int'(pb)) % 2 == int'(P_OD));
        good   = sb && par_ok;
        e_ovr  = 1'b0;
        if (good) begin
            if (!m_valid || rdy) begin
                m_data  = d;
                m_valid = 1'b1;
            end else begin
                e_ovr = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end

        check("p_data", 32'(p_data), 32'(m_data));
        check("p_valid", 32'(p_valid), 32'(m_valid));
        check("frame_err", 32'(frame_err), 32'(!sb));
        check("parity_err", 32'(parity_err), 32'(sb && !par_ok));
        check("overrun", 32'(overrun), 32'(e_ovr));
        check("busy_after_stop", 32'(busy), 32'd0);
        tick();
        check("pulses_one_cycle", 32'({parity_err, frame_err, overrun}),
              32'd0);
    endtask

    task automatic consume();
        p_ready = 1'b1;
        tick();
        p_ready = 1'b0;
        m_valid = 1'b0;
        check("consume_valid", 32'(p_valid), 32'd0);
        check("consume_data", 32'(p_data), 32'(m_data));
    endtask

    function automatic logic even_pb(input logic [W-1:0] d);
        return 1'(($countones(d) + int'(P_OD)) % 2);
    endfunction

    initial begin
        reset   = 1'b0;
        s_in    = 1'b1;
        s_valid = 1'b0;
        clr     = 1'b0;
        p_ready = 1'b0;
        m_data  = '0;
        m_valid = 1'b0;
        #12;
        check("rst_p_data", 32'(p_data), 32'd0);
        check("rst_p_valid", 32'(p_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pulses", 32'({parity_err, frame_err, overrun}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        send_frame(4'b1011, 1'b1, 1'b1, 0, 1'b0);
        consume();
        send_frame(4'b1011, 1'b0, 1'b1, 0, 1'b0);
        send_frame(4'b1011, 1'b1, 1'b0, 0, 1'b0);
        send_frame(4'b1011, 1'b0, 1'b0, 0, 1'b0);

        send_frame(4'hB, 1'b1, 1'b1, 0, 1'b0);
        send_frame(4'h5, 1'b0, 1'b1, 0, 1'b0);
        consume();

        send_frame(4'hB, 1'b1, 1'b1, 0, 1'b0);
        send_frame(4'h5, 1'b0, 1'b1, 0, 1'b1);
        consume();

        send_frame(4'hB, 1'b1, 1'b1, 3, 1'b0);
        consume();

        start_bits(4'hB, 2, 0);
        #2 reset = 1'b0;
        #1;
        m_data  = '0;
        m_valid = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_p_valid", 32'(p_valid), 32'd0);
        check("midrst_p_data", 32'(p_data), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        send_frame(4'h6, 1'b0, 1'b1, 1, 1'b0);

        start_bits(4'h9, 2, 0);
        clr = 1'b1;
        s_valid = 1'b1;
        s_in = 1'b1;
        p_ready = 1'b1;
        tick();
        clr = 1'b0;
        s_valid = 1'b0;
        p_ready = 1'b0;
        m_valid = 1'b0;
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_p_valid", 32'(p_valid), 32'd0);
        check("clr_p_data_kept", 32'(p_data), 32'(m_data));
        send_frame(4'h9, 1'b0, 1'b1, 0, 1'b0);
        consume();

        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] d;
            logic         pb;
            d  = W'($urandom);
            pb = even_pb(d);
            if ($urandom_range(0, 4) == 0)
                pb = !pb;
            send_frame(d, pb, ($urandom_range(0, 5) != 0),
                       int'($urandom_range(0, 3)),
                       1'($urandom));
            if ($urandom_range(0, 2) == 0)
                consume();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
